// File: rtl/fifo_pkg.sv
// Shared helpers and derived sizes for the FIFO controller.
// Width functions are used by the interface, the skid ring and the top.
package fifo_pkg;

    localparam int DEF_DEPTH      = 16;
    localparam int DEF_DATA_WIDTH = 32;
    localparam int DEF_OUTPUT_REG = 1;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

    function automatic int skid_depth(input int output_reg);
        return output_reg + 1;
    endfunction

    // Bits needed to hold a count of 0..n, never less than one.
    function automatic int cnt_width(input int n);
        return (n < 1) ? 1 : clog2(n + 1);
    endfunction

    // Pointer bits for an n-entry ring, never less than one.
    function automatic int ptr_width(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

    function automatic int count_width(input int depth, input int output_reg);
        return clog2(depth + skid_depth(output_reg) + 1);
    endfunction

endpackage

// File: rtl/fifo_if.sv
// Push/pop stream bundle plus occupancy status of the FIFO.
// The FIFO takes the slave side, the user logic the master side.
interface fifo_if
    import fifo_pkg::*;
#(
    parameter int DW = DEF_DATA_WIDTH,
    parameter int CW = count_width(DEF_DEPTH, DEF_OUTPUT_REG)
) ();

    logic          s_valid;
    logic          s_ready;
    logic [DW-1:0] s_data;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [CW-1:0] count;
    logic          almost_full;

    modport slave (
        input  s_valid, s_data, m_ready,
        output s_ready, m_valid, m_data, count, almost_full
    );

    modport master (
        output s_valid, s_data, m_ready,
        input  s_ready, m_valid, m_data, count, almost_full
    );

endinterface

// File: rtl/fifo_skid_buf.sv
// Small register ring that catches words leaving the RAM pipeline.
// Head word is presented straight from its register.
module fifo_skid_buf
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 2,
    parameter int DATA_WIDTH = 32,
    localparam int CNTW      = cnt_width(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr,
    input  logic                  push,
    input  logic [DATA_WIDTH-1:0] din,
    input  logic                  pop,
    output logic [DATA_WIDTH-1:0] dout,
    output logic [CNTW-1:0]       cnt
);

    localparam int PW = ptr_width(DEPTH);

    logic [DATA_WIDTH-1:0] ring [DEPTH];
    logic [PW-1:0]         wr_ptr;
    logic [PW-1:0]         rd_ptr;
    logic                  full;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full = (cnt == CNTW'(DEPTH));
    assign dout = ring[rd_ptr];

    // Ring pointers and fill level; same-cycle push and pop leave cnt alone.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clr) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (push) wr_ptr <= nxt(wr_ptr);
            if (pop)  rd_ptr <= nxt(rd_ptr);
            unique case (1'b1)
                push & ~pop: cnt <= cnt + 1'b1;
                ~push & pop: cnt <= cnt - 1'b1;
                default:     cnt <= cnt;
            endcase
        end
    end

    // Data storage needs no reset; cnt says which entries are live.
    always_ff @(posedge clk) begin
        if (push && !clr) ring[wr_ptr] <= din;
    end

    // The read credit keeps the ring from ever overflowing.
    a_no_overflow: assert property (
        @(posedge clk) disable iff (rst) !(push && full && !pop && !clr)
    );

endmodule

// File: rtl/fifo_ctrl.sv
// Single-clock FIFO controller sequencing an external dual-port RAM.
// Credit-gated read issue feeds a skid ring for full-rate FWFT pops.
module fifo_ctrl
    import fifo_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 4,
    parameter int OUTPUT_REG = 1,
    parameter int AF_THRESH  = 12
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    fifo_if.slave                 bus,
    output logic                  ram_rst_n,
    output logic                  ram_wr_en,
    output logic [ADDR_WIDTH-1:0] ram_wr_ptr,
    output logic [DATA_WIDTH-1:0] ram_wr_data,
    output logic                  ram_rd_en,
    output logic [ADDR_WIDTH-1:0] ram_rd_ptr,
    input  logic [DATA_WIDTH-1:0] ram_rd_data
);

    localparam int SKID_DEPTH = skid_depth(OUTPUT_REG);
    localparam int CW  = count_width(DEPTH, OUTPUT_REG);
    localparam int MCW = cnt_width(DEPTH);
    localparam int SCW = cnt_width(SKID_DEPTH);
    localparam int IFW = cnt_width(OUTPUT_REG);
    localparam int OW  = cnt_width(OUTPUT_REG + SKID_DEPTH);

    logic                  rst_done;
    logic [ADDR_WIDTH-1:0] wp;
    logic [ADDR_WIDTH-1:0] rp;
    logic [MCW-1:0]        mem_cnt;
    logic [IFW-1:0]        inflight;
    logic [SCW-1:0]        skid_cnt;
    logic [OW-1:0]         occ;
    logic [CW-1:0]         count;
    logic                  s_ready;
    logic                  m_valid;
    logic                  accept;
    logic                  pop;
    logic                  issue;
    logic                  land;

    // Handshakes and read credit: issue only while the skid can absorb it.
    always_comb begin
        s_ready = rst_done & ~flush & (mem_cnt != MCW'(DEPTH));
        accept  = bus.s_valid & s_ready;
        m_valid = (skid_cnt != '0);
        pop     = m_valid & bus.m_ready;
        occ     = OW'(inflight) + OW'(skid_cnt);
        issue   = (mem_cnt != '0) & ~flush
                & ((occ - OW'(pop)) < OW'(SKID_DEPTH));
    end

    // Holds s_ready low until the first edge after reset releases.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) rst_done <= 1'b0;
        else     rst_done <= 1'b1;
    end

    // RAM pointers and stored-word count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp      <= '0;
            rp      <= '0;
            mem_cnt <= '0;
        end else if (flush) begin
            wp      <= '0;
            rp      <= '0;
            mem_cnt <= '0;
        end else begin
            if (accept) wp <= wp + 1'b1;
            if (issue)  rp <= rp + 1'b1;
            unique case (1'b1)
                accept & ~issue: mem_cnt <= mem_cnt + 1'b1;
                ~accept & issue: mem_cnt <= mem_cnt - 1'b1;
                default:         mem_cnt <= mem_cnt;
            endcase
        end
    end

    if (OUTPUT_REG > 0) begin : g_pipe
        logic [OUTPUT_REG-1:0] vld_pipe;

        // Marks which RAM output stages carry a real read.
        always_ff @(posedge clk or posedge rst) begin
            if (rst)        vld_pipe <= '0;
            else if (flush) vld_pipe <= '0;
            else            vld_pipe <= OUTPUT_REG'({vld_pipe, issue});
        end

        assign inflight = IFW'($countones(vld_pipe));
        assign land     = vld_pipe[OUTPUT_REG-1];
    end else begin : g_nopipe
        assign inflight = '0;
        assign land     = issue;
    end

    fifo_skid_buf #(
        .DEPTH      (SKID_DEPTH),
        .DATA_WIDTH (DATA_WIDTH)
    ) u_skid (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .push (land),
        .din  (ram_rd_data),
        .pop  (pop),
        .dout (bus.m_data),
        .cnt  (skid_cnt)
    );

    assign count           = CW'(mem_cnt) + CW'(inflight) + CW'(skid_cnt);
    assign bus.s_ready     = s_ready;
    assign bus.m_valid     = m_valid;
    assign bus.count       = count;
    assign bus.almost_full = (count >= CW'(AF_THRESH));

    assign ram_rst_n   = ~rst;
    assign ram_wr_en   = accept;
    assign ram_wr_ptr  = wp;
    assign ram_wr_data = bus.s_data;
    assign ram_rd_en   = 1'b1;
    assign ram_rd_ptr  = rp;

endmodule

// File: tb/tb_fifo_ctrl.sv
// Bench for fifo_ctrl with OUTPUT_REG = 1, 0 and 3 driven in parallel.
// Each instance has its own RAM model and a queue-based scoreboard.
module tb_fifo_ctrl;
    import fifo_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        s_valid;
    logic        m_ready;
    logic [31:0] s_data;

    logic [2:0]  sr;
    logic [2:0]  mv;
    logic [2:0]  af;
    logic [31:0] md  [3];
    logic [7:0]  cnt [3];

    int          n_chk  = 0;
    int          n_fail = 0;
    logic [31:0] sb [3][$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    for (genvar g = 0; g < 3; g++) begin : inst
        localparam int OREG = (g == 0) ? 1 : (g == 1) ? 0 : 3;
        localparam int CWG  = count_width(16, OREG);

        fifo_if #(.DW(32), .CW(CWG)) bus ();

        logic        ram_rst_n;
        logic        wr_en;
        logic        rd_en;
        logic [3:0]  wr_ptr;
        logic [3:0]  rd_ptr;
        logic [31:0] wr_data;
        logic [31:0] rd_data;
        logic [31:0] mem [16];

        assign bus.s_valid = s_valid;
        assign bus.s_data  = s_data;
        assign bus.m_ready = m_ready;
        assign sr[g]  = bus.s_ready;
        assign mv[g]  = bus.m_valid;
        assign af[g]  = bus.almost_full;
        assign md[g]  = bus.m_data;
        assign cnt[g] = 8'(bus.count);

        fifo_ctrl #(
            .DEPTH      (16),
            .DATA_WIDTH (32),
            .ADDR_WIDTH (4),
            .OUTPUT_REG (OREG),
            .AF_THRESH  (12)
        ) dut (
            .clk         (clk),
            .rst         (rst),
            .flush       (flush),
            .bus         (bus),
            .ram_rst_n   (ram_rst_n),
            .ram_wr_en   (wr_en),
            .ram_wr_ptr  (wr_ptr),
            .ram_wr_data (wr_data),
            .ram_rd_en   (rd_en),
            .ram_rd_ptr  (rd_ptr),
            .ram_rd_data (rd_data)
        );

        always @(posedge clk) begin
            if (wr_en) mem[wr_ptr] <= wr_data;
        end

        if (OREG == 0) begin : g_comb
            assign rd_data = mem[rd_ptr];
        end else begin : g_reg
            logic [31:0] pipe [OREG];
            always @(posedge clk) begin
                if (!ram_rst_n) begin
                    for (int i = 0; i < OREG; i++) pipe[i] <= '0;
                end else if (rd_en) begin
                    pipe[0] <= mem[rd_ptr];
                    for (int i = 1; i < OREG; i++) pipe[i] <= pipe[i-1];
                end
            end
            assign rd_data = pipe[OREG-1];
        end
    end

    task automatic check(input string tag, input logic [63:0] obs,
                         input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: the FIFO holds exactly the accepted-but-not-popped words.
    task automatic sb_step();
        for (int g = 0; g < 3; g++) begin
            if (rst) begin
                check($sformatf("rst_count[%0d]", g), cnt[g], 0);
                sb[g].delete();
            end else begin
                check($sformatf("count[%0d]", g), cnt[g], sb[g].size());
                if (mv[g] && m_ready) begin
                    if (sb[g].size() == 0) begin
                        check($sformatf("spurious_valid[%0d]", g), mv[g], 0);
                    end else begin
                        check($sformatf("pop_data[%0d]", g), md[g], sb[g][0]);
                        void'(sb[g].pop_front());
                    end
                end
                if (flush) begin
                    check($sformatf("flush_ready[%0d]", g), sr[g], 0);
                    sb[g].delete();
                end else if (s_valid && sr[g]) begin
                    sb[g].push_back(s_data);
                end
            end
        end
    endtask

    task automatic sample();
        @(negedge clk);
        sb_step();
    endtask

    task automatic adv();
        @(posedge clk);
        #1;
    endtask

    task automatic tick();
        sample();
        adv();
    endtask

    // Leaves 10 words held in the main instance with one read in flight.
    task automatic prep_held();
        int   acc;
        logic took;
        acc     = 0;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h100;
        for (int i = 0; i < 40 && acc < 11; i++) begin
            sample();
            took = sr[0];
            adv();
            if (took) begin
                acc++;
                s_data = s_data + 1;
            end
        end
        s_valid = 1'b0;
        check("held_fill", acc, 11);
        m_ready = 1'b1;
        sample();
        check("held_pop_valid", mv[0], 1);
        adv();
        m_ready = 1'b0;
    endtask

    task automatic expect_first(input string tag);
        logic got;
        got     = 1'b0;
        s_valid = 1'b1;
        s_data  = 32'h1234;
        m_ready = 1'b1;
        sample();
        check({tag, "_ready"}, sr[0], 1);
        adv();
        s_valid = 1'b0;
        for (int k = 0; k < 8 && !got; k++) begin
            sample();
            if (mv[0]) begin
                got = 1'b1;
                check({tag, "_data"}, md[0], 32'h1234);
            end
            adv();
        end
        check({tag, "_seen"}, got, 1);
        repeat (6) tick();
    endtask

    initial begin
        int   acc;
        int   pushed;
        int   popped;
        int   gaps;
        logic took;

        rst     = 1'b1;
        flush   = 1'b0;
        s_valid = 1'b1;
        s_data  = '0;
        m_ready = 1'b0;

        // Reset with a pending push
        repeat (2) tick();
        sample();
        check("rst_ready", sr[0], 0);
        check("rst_valid", mv[0], 0);
        check("rst_count", cnt[0], 0);
        check("rst_af", af[0], 0);
        adv();
        rst = 1'b0;
        sample();
        check("rel_ready_before_edge", sr[0], 0);
        adv();
        s_valid = 1'b0;
        sample();
        check("rel_ready_after_edge", sr[0], 1);
        adv();

        // Single-word latency
        s_valid = 1'b1;
        s_data  = 32'hA5A5_0001;
        m_ready = 1'b1;
        sample();
        check("lat_ready", sr[0], 1);
        adv();
        s_valid = 1'b0;
        sample();
        check("lat_e0_valid", mv[0], 0);
        check("lat_e0_count", cnt[0], 1);
        adv();
        sample();
        check("lat_e1_valid", mv[0], 0);
        adv();
        sample();
        check("lat_e2_valid", mv[0], 1);
        check("lat_e2_data", md[0], 32'hA5A5_0001);
        adv();
        sample();
        check("lat_e3_valid", mv[0], 0);
        check("lat_e3_count", cnt[0], 0);
        adv();
        repeat (4) tick();

        // Fill to capacity with no pops
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = '0;
        acc     = 0;
        for (int i = 0; i < 40; i++) begin
            sample();
            took = sr[0];
            check("fill_af", af[0], (cnt[0] >= 12) ? 1 : 0);
            adv();
            if (took) begin
                acc++;
                s_data = 32'(acc);
            end
        end
        s_valid = 1'b0;
        sample();
        check("fill_accepts", acc, 18);
        check("fill_ready", sr[0], 0);
        check("fill_count", cnt[0], 18);
        check("fill_af_full", af[0], 1);
        adv();
        m_ready = 1'b1;
        for (int k = 0; k < 18; k++) begin
            sample();
            check($sformatf("drain_valid_%0d", k), mv[0], 1);
            check($sformatf("drain_data_%0d", k), md[0], k);
            adv();
        end
        sample();
        check("drain_empty", mv[0], 0);
        adv();
        repeat (4) tick();

        // Streaming with wrap, one word per cycle
        s_valid = 1'b1;
        m_ready = 1'b1;
        s_data  = 32'd100;
        pushed  = 0;
        popped  = 0;
        gaps    = 0;
        for (int i = 0; i < 200 && popped < 100; i++) begin
            sample();
            took = s_valid && sr[0];
            if (mv[0]) begin
                check("thru_data", md[0], 100 + popped);
                popped++;
            end else if (popped > 0) begin
                gaps++;
            end
            adv();
            if (took) begin
                pushed++;
                s_data = 32'(100 + pushed);
                if (pushed == 100) s_valid = 1'b0;
            end
        end
        check("thru_popped", popped, 100);
        check("thru_gaps", gaps, 0);
        repeat (6) tick();

        // Random traffic against the scoreboards
        for (int i = 0; i < 10000; i++) begin
            s_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 99) < ((i < 5000) ? 30 : 80));
            s_data  = $urandom;
            tick();
        end
        s_valid = 1'b0;
        m_ready = 1'b1;
        repeat (40) tick();
        sample();
        for (int g = 0; g < 3; g++) begin
            check($sformatf("rand_drained[%0d]", g), cnt[g], 0);
        end
        adv();

        // Flush with words held and one read in flight
        prep_held();
        flush   = 1'b1;
        s_valid = 1'b1;
        s_data  = 32'hDEAD_BEEF;
        sample();
        check("flush_cyc_ready", sr[0], 0);
        check("flush_cyc_count", cnt[0], 10);
        adv();
        flush   = 1'b0;
        s_valid = 1'b0;
        sample();
        check("flush_after_count", cnt[0], 0);
        check("flush_after_valid", mv[0], 0);
        adv();
        expect_first("flush_next");

        // Asynchronous reset mid-stream
        prep_held();
        rst = 1'b1;
        sample();
        check("mrst_ready", sr[0], 0);
        check("mrst_valid", mv[0], 0);
        check("mrst_count", cnt[0], 0);
        adv();
        tick();
        rst = 1'b0;
        tick();
        expect_first("mrst_next");

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
